// File: rtl/piso_serializer_if.sv
// Load handshake and serial-link bundle for piso_serializer.
// The master drives words in and watches the serial side; the slave is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             sd;
    logic             sd_valid;
    logic             frame;
    logic             busy;

    modport master (
        output load_valid, load_data,
        input  load_ready, sd, sd_valid, frame, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, sd, sd_valid, frame, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: LSB first, frame marks bit 0, optional even parity.
// Define PISO_PARITY_EN to append one even-parity bit after every word.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    piso_serializer_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
    logic             par;
`endif
    logic             sd_q;
    logic             sd_valid_q;
    logic             frame_q;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == SHIFT) && (cnt == LAST);

    // Ready opens on the final transmit cycle so back-to-back words leave no gap.
`ifdef PISO_PARITY_EN
    assign bus.load_ready = (state == IDLE) || (state == PARITY);
`else
    assign bus.load_ready = (state == IDLE) || last_bit;
`endif

    assign accept       = bus.load_valid && bus.load_ready;
    assign bus.busy     = (state != IDLE);
    assign bus.sd       = sd_q;
    assign bus.sd_valid = sd_valid_q;
    assign bus.frame    = frame_q;

    // Outputs lag the state by one cycle: each edge presents the bit the state selected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
            sd_q       <= 1'b0;
            sd_valid_q <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    sd_q       <= sr[cnt];
                    sd_valid_q <= 1'b1;
                    frame_q    <= (cnt == '0);
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    sd_q       <= par;
                    sd_valid_q <= 1'b1;
                    frame_q    <= 1'b0;
                end
`endif
                default: begin
                    sd_q       <= 1'b0;
                    sd_valid_q <= 1'b0;
                    frame_q    <= 1'b0;
                end
            endcase

            if (accept) begin
                sr    <= bus.load_data;
                cnt   <= '0;
`ifdef PISO_PARITY_EN
                par   <= ^bus.load_data;
`endif
                state <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        if (last_bit) begin
`ifdef PISO_PARITY_EN
                            state <= PARITY;
`else
                            state <= IDLE;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef PISO_PARITY_EN
                    PARITY: state <= IDLE;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
